valid_counter_bank: RTL
=======================

// Module: valid_counter_bank
// PURPOSE
//   Multi-channel, width-parametrised counter of validtocounter pulses; next generation of the
//   single 8-bit validin counter. Each channel is loadable and clearable, and counts in wrap or
//   saturate mode. Each channel flags terminal count and holds a sticky overflow.
//   Sits between the stream-valid sources and the status/control register block.
// PARAMETERS
//   WIDTH     8    counter width per channel (>=2)
//   CHANNELS  1    number of independent channels (>=1)
//   RST_VAL   0    per-channel value after reset and after clear (WIDTH bits)
// PORTS
//   clk             in   1               single clock, rising edge
//   rst             in   1               asynchronous, active-high reset
//   load            in   CHANNELS        per-channel load strobe
//   load_val        in   CHANNELS*WIDTH  load value, channel c = [c*WIDTH +: WIDTH]
//   validtocounter  in   CHANNELS        per-channel count-enable pulse
//   clear           in   1               synchronous clear, all channels
//   mode_sat        in   1               1 = saturate at max; 0 = wrap to 0
//   ovf_clr         in   CHANNELS        clears the sticky overflow
//   validin         out  CHANNELS*WIDTH  registered count, same packing as load_val
//   tc              out  CHANNELS        registered; 1 while count == 2^WIDTH-1
//   ovf             out  CHANNELS        sticky; set on a wrap or saturation-blocked increment
// BEHAVIOUR
//   - rst=1 (async): validin=RST_VAL, tc=(RST_VAL==max), ovf=0. Takes effect immediately,
//     including mid-count; the first count is accepted on the first edge after release.
//   - Per-channel priority each edge: clear > load > validtocounter > hold.
//   - clear: count=RST_VAL; ovf unaffected. Not a reset.
//   - load: count=load_val; a coincident validtocounter is dropped, with no +1.
//   - Increment, 1-cycle latency: a pulse at edge N is visible on validin after edge N.
//     - count<max: count+1.
//     - count==max, mode_sat=0: count->0, ovf<=1.
//     - count==max, mode_sat=1: count holds max, ovf<=1.
//   - Width rule: unsigned, modulo 2^WIDTH; no carry output.
//   - tc is derived from the next-count value, so it is valid in the same cycle as validin.
//   - ovf: set dominates ovf_clr in the same cycle; ovf_clr alone -> 0 next edge.
//   - mode_sat may change any cycle and applies to that edge's increment only.
//   - Channels are fully independent; only clear and mode_sat are shared.
// CONFIGURATION
//   Macro VALID_COUNTER_BANK_THRESH_EN.
//   Defined:
//     - Adds input thresh[CHANNELS*WIDTH] and output thr_hit[CHANNELS].
//     - thr_hit is registered, 1 while count >= thresh (unsigned); reset value 0.
//     - thr_hit is updated on the same edge as validin.
//   Undefined: neither port exists and no compare logic is built.
// STRUCTURE
//   - Package valid_counter_pkg holds:
//     - typedef of the count_t WIDTH-bit vector;
//     - localparam CNT_MAX function;
//     - typedef enum {MODE_WRAP, MODE_SAT} mode_e.
//   - Sub-module valid_counter_chan: one channel (count, tc, ovf, optional thr_hit).
//   - The top instantiates valid_counter_chan in a generate loop over CHANNELS and does the
//     port slicing.
// TESTING
//   1. W=8, C=1, RST_VAL=0:
//      rst pulse mid-cycle -> validin=0, tc=0, ovf=0 asynchronously.
//      3 valid pulses -> validin=3.
//   2. load=1 with load_val=8'hFD and validtocounter=1 on the same edge -> validin=FD (pulse
//      dropped). Then valid x2 -> FF, tc=1.
//   3. Wrap, mode_sat=0, count=FF:
//      valid -> validin=00, ovf=1, tc=0.
//      ovf_clr and valid on the same edge at FF -> ovf stays 1.
//   4. Saturate, mode_sat=1, count=FF:
//      valid x3 -> validin stays FF, ovf=1.
//      ovf_clr alone -> ovf=0 next edge.
//   5. C=4, W=4:
//      independent pulses per channel -> each slice counts only its own pulses.
//      clear -> all =RST_VAL, ovf bits unchanged.
//   6. THRESH_EN defined, thresh=5: count 4->5 -> thr_hit 0->1 on the same edge.
//      load 2 -> thr_hit=0.

Source files
------------

// File: rtl/valid_counter_bank_pkg.sv
// Shared types and helpers for the valid-pulse counter bank.
// Built with or without VALID_COUNTER_BANK_THRESH_EN; nothing here depends on it.
package valid_counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // All-ones value for a counter of the given width (widths up to 64).
    function automatic logic [63:0] cnt_max(input int unsigned width);
        if (width >= 64)
            return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

    localparam logic [63:0] CNT_MAX = cnt_max(DEFAULT_WIDTH);

endpackage

// File: rtl/valid_counter_bank_if.sv
// Control/status bundle between the valid sources, the register block and the counter bank.
// VALID_COUNTER_BANK_THRESH_EN adds the per-channel threshold input and hit flag.
interface valid_counter_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 1
);

    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] load_val;
    logic [CHANNELS-1:0]       validtocounter;
    logic                      clear;
    logic                      mode_sat;
    logic [CHANNELS-1:0]       ovf_clr;
    logic [CHANNELS*WIDTH-1:0] validin;
    logic [CHANNELS-1:0]       tc;
    logic [CHANNELS-1:0]       ovf;
`ifdef VALID_COUNTER_BANK_THRESH_EN
    logic [CHANNELS*WIDTH-1:0] thresh;
    logic [CHANNELS-1:0]       thr_hit;

    modport master (
        output load, load_val, validtocounter, clear, mode_sat, ovf_clr, thresh,
        input  validin, tc, ovf, thr_hit
    );

    modport slave (
        input  load, load_val, validtocounter, clear, mode_sat, ovf_clr, thresh,
        output validin, tc, ovf, thr_hit
    );
`else
    modport master (
        output load, load_val, validtocounter, clear, mode_sat, ovf_clr,
        input  validin, tc, ovf
    );

    modport slave (
        input  load, load_val, validtocounter, clear, mode_sat, ovf_clr,
        output validin, tc, ovf
    );
`endif

endinterface

// File: rtl/valid_counter_bank_chan.sv
// One counter channel: count, terminal-count flag, sticky overflow and optional threshold hit.
// VALID_COUNTER_BANK_THRESH_EN enables the threshold compare.
module valid_counter_chan
    import valid_counter_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             clear,
    input  logic             mode_sat,
    input  logic             ovf_clr,
`ifdef VALID_COUNTER_BANK_THRESH_EN
    input  logic [WIDTH-1:0] thresh,
    output logic             thr_hit,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

    mode_e            mode;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_set;

    assign mode = mode_e'(mode_sat);

    // Priority: clear, then load (which swallows a coincident pulse), then increment.
    always_comb begin
        count_nxt = count;
        ovf_set   = 1'b0;
        if (clear) begin
            count_nxt = RST_VAL;
        end else if (load) begin
            count_nxt = load_val;
        end else if (inc) begin
            if (count == MAX) begin
                ovf_set   = 1'b1;
                count_nxt = (mode == MODE_SAT) ? MAX : '0;
            end else begin
                count_nxt = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_VAL;
            tc    <= (RST_VAL == MAX);
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= (count_nxt == MAX);
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

`ifdef VALID_COUNTER_BANK_THRESH_EN
    // Compared against the next count so the flag lines up with validin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            thr_hit <= 1'b0;
        else
            thr_hit <= (count_nxt >= thresh);
    end
`endif

endmodule

// File: rtl/valid_counter_bank.sv
// Bank of independent valid-pulse counters; clear and mode_sat are shared across channels.
// VALID_COUNTER_BANK_THRESH_EN adds thresh/thr_hit on the interface.
module valid_counter_bank
    import valid_counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               CHANNELS = 1,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    valid_counter_bank_if.slave  bus
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        valid_counter_chan #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .load     (bus.load[c]),
            .load_val (bus.load_val[c*WIDTH +: WIDTH]),
            .inc      (bus.validtocounter[c]),
            .clear    (bus.clear),
            .mode_sat (bus.mode_sat),
            .ovf_clr  (bus.ovf_clr[c]),
`ifdef VALID_COUNTER_BANK_THRESH_EN
            .thresh   (bus.thresh[c*WIDTH +: WIDTH]),
            .thr_hit  (bus.thr_hit[c]),
`endif
            .count    (bus.validin[c*WIDTH +: WIDTH]),
            .tc       (bus.tc[c]),
            .ovf      (bus.ovf[c])
        );
    end

endmodule
